// File: rtl/bus_select_arbiter.sv
// Bus ownership arbiter feeding the 32:1 datapath mux: registered select/grant,
// optional hold-time preemption, saturating conflict counter. BUS_ARB_ROUND_ROBIN_EN selects round-robin.
module bus_select_arbiter #(
    parameter logic [4:0] IDLE_SEL = 5'd0,
    parameter int         MAX_HOLD = 0,
    parameter int         CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      req,
    output logic [4:0]       select,
    output logic [31:0]      grant,
    output logic             bus_valid,
    output logic [CNT_W-1:0] conflict_cnt
);

    typedef enum logic {IDLE, OWNED} state_t;

    localparam logic [7:0] HOLD_LIM = MAX_HOLD[7:0];

    state_t           state_reg, state_next;
    logic [4:0]       owner_reg, owner_next;
    logic [7:0]       hold_cnt_reg, hold_cnt_next;
    logic [4:0]       select_reg, select_next;
    logic [31:0]      grant_reg, grant_next;
    logic             bus_valid_reg, bus_valid_next;
    logic [CNT_W-1:0] conflict_cnt_reg;

    logic [31:0] cand_req;
    logic        any_cand;
    logic [4:0]  winner;
    logic        preempt;
    logic        do_grant;
    logic        multi_req;

    function automatic logic [4:0] lowest_set(input logic [31:0] v);
        logic [4:0] r;
        r = '0;
        for (int i = 31; i >= 0; i--) begin
            if (v[i]) r = 5'(i);
        end
        return r;
    endfunction

    // The current owner never competes when choosing its successor.
    assign cand_req = (state_reg == OWNED) ? (req & ~(32'd1 << owner_reg)) : req;
    assign any_cand = |cand_req;

`ifdef BUS_ARB_ROUND_ROBIN_EN
    logic [4:0]  ptr_reg, ptr_next;
    logic [31:0] rot_req;

    // Rotate so that bit 0 of rot_req corresponds to index ptr_reg.
    for (genvar gi = 0; gi < 32; gi++) begin : g_rot
        assign rot_req[gi] = cand_req[5'(ptr_reg + 5'(gi))];
    end

    assign winner = ptr_reg + lowest_set(rot_req);
`else
    assign winner = lowest_set(cand_req);
`endif

    assign preempt = (MAX_HOLD != 0) && (hold_cnt_reg >= HOLD_LIM) && any_cand;

    always_comb begin
        state_next     = state_reg;
        owner_next     = owner_reg;
        hold_cnt_next  = hold_cnt_reg;
        select_next    = select_reg;
        grant_next     = grant_reg;
        bus_valid_next = bus_valid_reg;
        do_grant       = 1'b0;
`ifdef BUS_ARB_ROUND_ROBIN_EN
        ptr_next       = ptr_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (|req) do_grant = 1'b1;
            end
            OWNED: begin
                if (!req[owner_reg]) begin
                    if (any_cand) begin
                        do_grant = 1'b1;
                    end else begin
                        state_next     = IDLE;
                        select_next    = IDLE_SEL;
                        grant_next     = '0;
                        bus_valid_next = 1'b0;
                    end
                end else if (preempt) begin
                    do_grant = 1'b1;
                end else if (hold_cnt_reg != 8'hFF) begin
                    hold_cnt_next = hold_cnt_reg + 8'd1;
                end
            end
            default: state_next = IDLE;
        endcase

        if (do_grant) begin
            state_next     = OWNED;
            owner_next     = winner;
            select_next    = winner;
            grant_next     = 32'd1 << winner;
            bus_valid_next = 1'b1;
            hold_cnt_next  = 8'd1;
`ifdef BUS_ARB_ROUND_ROBIN_EN
            ptr_next       = winner + 5'd1;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            owner_reg     <= '0;
            hold_cnt_reg  <= '0;
            select_reg    <= IDLE_SEL;
            grant_reg     <= '0;
            bus_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            owner_reg     <= owner_next;
            hold_cnt_reg  <= hold_cnt_next;
            select_reg    <= select_next;
            grant_reg     <= grant_next;
            bus_valid_reg <= bus_valid_next;
        end
    end

`ifdef BUS_ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_reg <= '0;
        else        ptr_reg <= ptr_next;
    end
`endif

    // Two or more bits set exactly when clearing the lowest set bit leaves something.
    assign multi_req = (req & (req - 32'd1)) != 32'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conflict_cnt_reg <= '0;
        end else if (multi_req && (conflict_cnt_reg != {CNT_W{1'b1}})) begin
            conflict_cnt_reg <= conflict_cnt_reg + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign select       = select_reg;
    assign grant        = grant_reg;
    assign bus_valid    = bus_valid_reg;
    assign conflict_cnt = conflict_cnt_reg;

endmodule

// File: tb/tb_bus_select_arbiter.sv
// Directed scoreboard bench for bus_select_arbiter: three instances (default,
// preempting with MAX_HOLD=4, and a 2-bit conflict counter) share req/rst_n.
module tb_bus_select_arbiter;

    logic        clk;
    logic        rst_n;
    logic [31:0] req;

    logic [4:0]  sel_m, sel_p, sel_c;
    logic [31:0] gnt_m, gnt_p, gnt_c;
    logic        vld_m, vld_p, vld_c;
    logic [7:0]  cnt_m, cnt_p;
    logic [1:0]  cnt_c;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          dut;
        string       tag;
        logic [4:0]  sel;
        logic [31:0] gnt;
        logic        vld;
        bit          chk_cnt;
        logic [7:0]  cnt;
    } exp_t;

    exp_t exp_q[$];

    bus_select_arbiter u_main (
        .clk(clk), .rst_n(rst_n), .req(req),
        .select(sel_m), .grant(gnt_m), .bus_valid(vld_m), .conflict_cnt(cnt_m)
    );

    bus_select_arbiter #(.IDLE_SEL(5'd30), .MAX_HOLD(4)) u_pre (
        .clk(clk), .rst_n(rst_n), .req(req),
        .select(sel_p), .grant(gnt_p), .bus_valid(vld_p), .conflict_cnt(cnt_p)
    );

    bus_select_arbiter #(.CNT_W(2)) u_cnt (
        .clk(clk), .rst_n(rst_n), .req(req),
        .select(sel_c), .grant(gnt_c), .bus_valid(vld_c), .conflict_cnt(cnt_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic expect_out(input int dut, input string tag, input logic [4:0] s,
                              input logic [31:0] g, input logic v,
                              input bit cc, input logic [7:0] c);
        exp_t e;
        e.dut = dut; e.tag = tag; e.sel = s; e.gnt = g; e.vld = v;
        e.chk_cnt = cc; e.cnt = c;
        exp_q.push_back(e);
    endtask

    task automatic check_now();
        exp_t        e;
        logic [4:0]  s;
        logic [31:0] g;
        logic        v;
        logic [7:0]  c;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            case (e.dut)
                0:       begin s = sel_m; g = gnt_m; v = vld_m; c = cnt_m; end
                1:       begin s = sel_p; g = gnt_p; v = vld_p; c = cnt_p; end
                default: begin s = sel_c; g = gnt_c; v = vld_c; c = {6'b0, cnt_c}; end
            endcase
            chk({e.tag, ".select"}, 32'(s), 32'(e.sel));
            chk({e.tag, ".grant"}, g, e.gnt);
            chk({e.tag, ".bus_valid"}, 32'(v), 32'(e.vld));
            if (e.chk_cnt) chk({e.tag, ".conflict_cnt"}, 32'(c), 32'(e.cnt));
            $display("txn %s dut%0d: select=%0d grant=%08h bus_valid=%0b conflict_cnt=%0d",
                     e.tag, e.dut, s, g, v, c);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        check_now();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 32'hFFFF_FFFF;

        // Reset with every request asserted; nothing may be granted or counted.
        @(posedge clk);
        @(posedge clk);
        #1;
        expect_out(0, "rst_main", 5'd0, 32'h0, 1'b0, 1, 8'd0);
        expect_out(1, "rst_pre", 5'd30, 32'h0, 1'b0, 1, 8'd0);
        expect_out(2, "rst_cnt", 5'd0, 32'h0, 1'b0, 1, 8'd0);
        check_now();
        req   = '0;
        rst_n = 1'b1;
        expect_out(0, "idle", 5'd0, 32'h0, 1'b0, 1, 8'd0);
        tick();

        // Single request from source 19 for three cycles.
        for (int k = 0; k < 3; k++) begin
            req = 32'd1 << 19;
            expect_out(0, "single", 5'd19, 32'h0008_0000, 1'b1, 1, 8'd0);
            tick();
        end
        req = '0;
        expect_out(0, "single_rel", 5'd0, 32'h0, 1'b0, 0, 8'd0);
        tick();

`ifdef BUS_ARB_ROUND_ROBIN_EN
        do_reset();
        req = (32'd1 << 31) | (32'd1 << 2);
        expect_out(0, "rr_a", 5'd2, 32'h0000_0004, 1'b1, 1, 8'd1);
        tick();
        req = 32'd1 << 31;
        expect_out(0, "rr_b", 5'd31, 32'h8000_0000, 1'b1, 0, 8'd0);
        tick();
        req = 32'd1 << 2;
        expect_out(0, "rr_c", 5'd2, 32'h0000_0004, 1'b1, 0, 8'd0);
        tick();
        req = '0;
        expect_out(0, "rr_idle", 5'd0, 32'h0, 1'b0, 1, 8'd1);
        tick();
        // Pointer now sits at 3, so 31 beats 2 on a fresh contention.
        req = (32'd1 << 31) | (32'd1 << 2);
        expect_out(0, "rr_ptr3", 5'd31, 32'h8000_0000, 1'b1, 1, 8'd2);
        tick();
        req = '0;
        expect_out(0, "rr_idle2", 5'd0, 32'h0, 1'b0, 0, 8'd0);
        tick();
`else
        req = 32'h0000_0030;
        expect_out(0, "fp_a", 5'd4, 32'h0000_0010, 1'b1, 1, 8'd1);
        tick();
        expect_out(0, "fp_b", 5'd4, 32'h0000_0010, 1'b1, 1, 8'd2);
        tick();
        req = 32'h0000_0020;
        expect_out(0, "fp_c", 5'd5, 32'h0000_0020, 1'b1, 1, 8'd2);
        tick();
        expect_out(0, "fp_d", 5'd5, 32'h0000_0020, 1'b1, 0, 8'd0);
        tick();
        req = '0;
        expect_out(0, "fp_idle", 5'd0, 32'h0, 1'b0, 1, 8'd2);
        tick();
`endif

        // Preemption: source 7 held, source 9 joins on the second cycle.
        do_reset();
        req = 32'd1 << 7;
        expect_out(1, "pre_1", 5'd7, 32'h0000_0080, 1'b1, 0, 8'd0);
        tick();
        req = (32'd1 << 7) | (32'd1 << 9);
        for (int k = 2; k <= 4; k++) begin
            expect_out(1, $sformatf("pre_%0d", k), 5'd7, 32'h0000_0080, 1'b1, 0, 8'd0);
            tick();
        end
        expect_out(1, "pre_5", 5'd9, 32'h0000_0200, 1'b1, 0, 8'd0);
        expect_out(0, "nopre_5", 5'd7, 32'h0000_0080, 1'b1, 0, 8'd0);
        tick();
        for (int k = 6; k <= 8; k++) begin
            expect_out(1, $sformatf("pre_%0d", k), 5'd9, 32'h0000_0200, 1'b1, 0, 8'd0);
            tick();
        end
        expect_out(1, "pre_9", 5'd7, 32'h0000_0080, 1'b1, 0, 8'd0);
        expect_out(0, "nopre_9", 5'd7, 32'h0000_0080, 1'b1, 1, 8'd8);
        tick();
        req = '0;
        expect_out(1, "pre_idle", 5'd30, 32'h0, 1'b0, 0, 8'd0);
        tick();

        // Conflict counter saturation at 2 bits versus 8 bits.
        do_reset();
        req = 32'h0000_0003;
        for (int k = 1; k <= 6; k++) begin
            expect_out(2, $sformatf("sat_%0d", k), 5'd0, 32'h0000_0001, 1'b1, 1,
                       (k > 3) ? 8'd3 : 8'(k));
            expect_out(0, $sformatf("cnt8_%0d", k), 5'd0, 32'h0000_0001, 1'b1, 1, 8'(k));
            tick();
        end

        // Asynchronous reset mid-cycle must clear outputs before any edge.
        #2;
        rst_n = 1'b0;
        #1;
        chk("async.grant", gnt_c, 32'h0);
        chk("async.bus_valid", 32'(vld_c), 32'h0);
        chk("async.conflict_cnt", 32'(cnt_c), 32'h0);
        chk("async.main_grant", gnt_m, 32'h0);
        chk("async.pre_select", 32'(sel_p), 32'd30);
        $display("txn async_reset: grant=%08h bus_valid=%0b conflict_cnt=%0d", gnt_c, vld_c, cnt_c);
        @(posedge clk);
        #1;
        req   = '0;
        rst_n = 1'b1;
        expect_out(2, "post_rst", 5'd0, 32'h0, 1'b0, 1, 8'd0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
